// File: rtl/frame_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// frame_mem_arbiter_if
// Bundles the camera write port, display read port, frame-memory port and the
// overflow status/clear pair of the frame-memory arbiter.
//   slave  : the arbiter side (takes requests and memory read data, drives the
//            memory strobe/address/data, read results and status)
//   master : the surrounding side (camera/display clients and the memory)
// Parameters: ADDR_W pixel address width, DATA_W pixel width.
// -----------------------------------------------------------------------------
interface frame_mem_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 3
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_full;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              ovf_clr;
    logic              overflow;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata, ovf_clr,
        output wr_full, rd_data, rd_valid, mem_en, mem_we, mem_addr, mem_wdata,
               overflow
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata, ovf_clr,
        input  wr_full, rd_data, rd_valid, mem_en, mem_we, mem_addr, mem_wdata,
               overflow
    );
endinterface

// File: rtl/frame_mem_arbiter.sv
// -----------------------------------------------------------------------------
// frame_mem_arbiter
// Owns the single frame-memory port and grants one access per clk_50 cycle.
// Display reads always win; camera writes are buffered in a small FIFO and
// drained in idle read slots. Writes that arrive while the FIFO is full and
// cannot drain are dropped and flagged in the sticky 'overflow' bit.
//
// Ports:
//   clk_50    system clock, rising edge
//   reset     asynchronous, active-high
//   bus       frame_mem_arbiter_if.slave (write/read clients, memory port,
//             ovf_clr / overflow)
//   ovf_count saturating 8-bit dropped-write counter, present only when the
//             macro FRAME_MEM_ARB_OVF_CNT_EN is defined
//
// Read latency is fixed at 3 cycles from the sampled rd_req to rd_valid.
// All outputs are registered except wr_full, which decodes the count register.
// -----------------------------------------------------------------------------
module frame_mem_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_50,
    input  logic                  reset,
    frame_mem_arbiter_if.slave    bus
`ifdef FRAME_MEM_ARB_OVF_CNT_EN
    ,
    output logic [7:0]            ovf_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // FIFO storage (data path only, no reset needed: validity is set by count)
    logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              rd_pipe_r;   // a read strobe was on the port last cycle
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              overflow_r;

    logic full_s;
    logic pop_s;
    logic push_s;
    logic drop_s;

    // Grant decision and FIFO push/pop/drop qualification
    always_comb begin
        full_s = (count_r == DEPTH_C);
        pop_s  = 1'b0;
        if (bus.rd_req) begin
            pop_s = 1'b0;
        end else if (count_r != CNT_W'(0)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        // A full FIFO still accepts a write when the head drains this cycle.
        push_s = bus.wr_req && (!full_s || pop_s);
        drop_s = bus.wr_req && full_s && !pop_s;
    end

    // FIFO entry write
    always_ff @(posedge clk_50) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= bus.wr_addr;
            fifo_data_r[wr_ptr_r] <= bus.wr_data;
        end
    end

    // FIFO bookkeeping, memory port, read return pipeline and overflow flag
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= PTR_W'(0);
            rd_ptr_r    <= PTR_W'(0);
            count_r     <= CNT_W'(0);
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= ADDR_W'(0);
            mem_wdata_r <= DATA_W'(0);
            rd_pipe_r   <= 1'b0;
            rd_data_r   <= DATA_W'(0);
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase

            // Address/data hold their last value on idle cycles.
            if (bus.rd_req) begin
                mem_en_r   <= 1'b1;
                mem_we_r   <= 1'b0;
                mem_addr_r <= bus.rd_addr;
            end else if (pop_s) begin
                mem_en_r    <= 1'b1;
                mem_we_r    <= 1'b1;
                mem_addr_r  <= fifo_addr_r[rd_ptr_r];
                mem_wdata_r <= fifo_data_r[rd_ptr_r];
            end else begin
                mem_en_r <= 1'b0;
                mem_we_r <= 1'b0;
            end

            // Memory returns data the cycle after the strobe; capture it then.
            rd_pipe_r  <= mem_en_r && !mem_we_r;
            rd_valid_r <= rd_pipe_r;
            if (rd_pipe_r) begin
                rd_data_r <= bus.mem_rdata;
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

`ifdef FRAME_MEM_ARB_OVF_CNT_EN
    logic [7:0] ovf_cnt_r;

    // Saturating dropped-write counter; a coincident clear and drop yields 1
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            ovf_cnt_r <= 8'd0;
        end else if (drop_s && bus.ovf_clr) begin
            ovf_cnt_r <= 8'd1;
        end else if (bus.ovf_clr) begin
            ovf_cnt_r <= 8'd0;
        end else if (drop_s && (ovf_cnt_r != 8'hFF)) begin
            ovf_cnt_r <= ovf_cnt_r + 8'd1;
        end
    end

    assign ovf_count = ovf_cnt_r;
`endif

    assign bus.wr_full   = full_s;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.rd_data   = rd_data_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: doc/frame_mem_arbiter.md
# frame_mem_arbiter

Single-port frame-memory arbiter between the camera pixel writer and the VGA pixel reader. It owns the one memory port of the frame table and grants one access per `clk_50` cycle. The display reader always has priority, and camera writes are absorbed in a small FIFO. It sits between `vga_camera`/`vga_display` and the frame table, replacing their direct connections to it.

## Interface
Parameters:
- `ADDR_W`, 17, pixel address width (320x240 = 76800 locations).
- `DATA_W`, 3, pixel width (RGB 1:1:1).
- `FIFO_DEPTH`, 4, write FIFO entries; power of 2, 2..16.

Ports (one clock; reset is asynchronous and active-high):
- `clk_50`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_req`  in  1  camera write request, one pixel per high cycle.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write pixel.
- `wr_full`  out  1  FIFO count == FIFO_DEPTH (combinational from count register).
- `rd_req`  in  1  display read request, one pixel per high cycle.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  DATA_W  read pixel.
- `rd_valid`  out  1  `rd_data` valid, single-cycle pulse per accepted read.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  1 = write, 0 = read; meaningful only with `mem_en`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; synchronous, valid the cycle after a read strobe.
- `ovf_clr`  in  1  clears `overflow` (and `ovf_count` when compiled in).
- `overflow`  out  1  sticky: a write was dropped.

## Operation
- FIFO holds {addr, data} pairs, with a count register of width clog2(FIFO_DEPTH)+1.
- Push condition: `wr_req` && (count < FIFO_DEPTH || pop this cycle). A push while full with a same-cycle pop is accepted; count is unchanged.
- Drop condition: `wr_req` while full with no pop. The write is discarded and `overflow` is set on the next edge.
- Grant per cycle, fixed priority:
  - `rd_req` high: issue a read.
  - Else if count > 0: pop the head and issue a write.
  - Else: idle.
- A write never preempts a read. Writes starve for as long as `rd_req` is held; the FIFO absorbs the gap.
- A write pushed in cycle N is earliest poppable in cycle N+1 (no FIFO bypass).
- Read-after-write ordering is not enforced. A read of an address still queued in the FIFO returns the old memory content.
- `ovf_clr` and a drop in the same cycle: set wins, `overflow` = 1.

## Timing
- All outputs are registered except `wr_full`.
- Read latency: `rd_req` sampled at edge N → `mem_en=1`, `mem_we=0` during cycle N+1 → `mem_rdata` during N+2 → registered `rd_data`/`rd_valid` during N+3. Fixed 3 cycles; back-to-back reads give one result per cycle.
- Write: pop at edge N → `mem_en=1`, `mem_we=1`, address/data driven during cycle N+1.
- `mem_en=0` in idle cycles. `mem_addr` and `mem_wdata` hold their last value.
- Reset values (asynchronous): count=0, FIFO pointers=0, `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `rd_data=0`, `rd_valid=0`, `overflow=0`, `wr_full=0`.
- Reset mid-operation: in-flight reads are discarded (no `rd_valid` after reset release) and queued writes are lost.
- First cycle after reset release: requests are accepted normally.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Configuration
- `FRAME_MEM_ARB_OVF_CNT_EN`: compiled in, adds output port `ovf_count`  out  8, a saturating count of dropped writes.
  - Increments by 1 per drop and sticks at 255.
  - `ovf_clr` resets it to 0. Drop and clear in the same cycle: result is 1.
  - Reset value 0.
- Not defined: the port and counter are absent; `overflow` behaviour is identical.

## Test plan
- Reset, then `rd_req`=1 for one cycle at addr 0x00010, with memory model holding 3'b101 there → `mem_en`/`mem_we=0`/`mem_addr=0x00010` in N+1; `rd_valid`=1 with `rd_data`=3'b101 in N+3 only.
- `wr_req` for 3 cycles (addr 1,2,3, data 1,2,3) with `rd_req`=0 → three memory writes in consecutive cycles starting at N+2, in order; `wr_full` never asserts.
- `rd_req` held 10 cycles while `wr_req` issues 6 writes → `wr_full`=1 after 4 pushes; 2 drops; `overflow`=1; `ovf_count`=2 when compiled in; after `rd_req` drops, exactly 4 writes issue in push order.
- FIFO full, `rd_req`=0, `wr_req`=1 → push accepted with same-cycle pop, count stays 4, `overflow` stays 0.
- Assert `reset` one cycle after a read is accepted → no `rd_valid`, all outputs 0, FIFO empty.
- With the macro defined: 300 drops → `ovf_count`=255; assert `ovf_clr` → 0; `ovf_clr` coincident with a drop → 1.
